// File: rtl/pixel_ram_writer_if.sv
// Pixel RAM writer bus bundle.
// Groups the frame-load control, the byte stream and the RAM port-A write
// signals so they travel as one port.
//   master : the stream/control source (drives start, base_addr, in_*),
//            observes the writer outputs.
//   slave  : the writer itself.
// Signals:
//   start       - one-cycle request to begin a frame load
//   base_addr   - first word address, sampled on an accepted start
//   in_valid    - in_data/in_last valid
//   in_ready    - writer accepts a byte this cycle
//   in_data     - pixel byte
//   in_last     - final byte of the frame
//   address_a   - RAM port-A word address
//   data_a      - RAM port-A write data
//   byteena_a   - RAM port-A byte enables
//   wren_a      - RAM port-A write strobe
//   busy        - high from an accepted start until done
//   done        - one-cycle completion pulse
//   short_frame - sticky: in_last came before a full frame
interface pixel_ram_writer_if;
  logic        start;
  logic [16:0] base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic [16:0] address_a;
  logic [31:0] data_a;
  logic [3:0]  byteena_a;
  logic        wren_a;
  logic        busy;
  logic        done;
  logic        short_frame;

  modport master (
    output start, base_addr, in_valid, in_data, in_last,
    input  in_ready, address_a, data_a, byteena_a, wren_a, busy, done, short_frame
  );

  modport slave (
    input  start, base_addr, in_valid, in_data, in_last,
    output in_ready, address_a, data_a, byteena_a, wren_a, busy, done, short_frame
  );
endinterface

// File: rtl/pixel_ram_writer.sv
// Pixel RAM writer.
// Accepts a stream of 8-bit pixels, packs them little-endian into 32-bit
// words and writes each word to RAM port A at consecutive word addresses
// starting at base_addr. A frame ends on in_last or after FRAME_BYTES bytes,
// whichever comes first. The RAM is never read.
// Ports:
//   i_clk   - clock, rising edge
//   i_rst_n - asynchronous active-low reset
//   bus     - pixel_ram_writer_if.slave (control, byte stream, RAM port A)
module pixel_ram_writer #(
  parameter int unsigned FRAME_BYTES = 65536
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  pixel_ram_writer_if.slave   bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [19:0] FRAME_LEN = 20'(FRAME_BYTES);

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic [16:0] r_addr;
  logic [31:0] r_pack;
  logic [3:0]  r_be;
  logic [19:0] r_count;
  logic        r_last;
  logic        r_short;

  logic        w_accept;
  logic [19:0] w_count_inc;
  logic [1:0]  w_lane;
  logic        w_word_end;
  logic        w_frame_end;

  assign w_accept    = bus.in_valid && (r_state == ST_FILL);
  assign w_count_inc = r_count + 20'd1;
  // Words always start aligned to the frame, so the lane is the count LSBs.
  assign w_lane      = r_count[1:0];
  assign w_word_end  = (w_lane == 2'd3) || bus.in_last || (w_count_inc == FRAME_LEN);
  assign w_frame_end = r_last || (r_count == FRAME_LEN);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start) w_state_next = ST_FILL;
      ST_FILL:  if (w_accept && w_word_end) w_state_next = ST_WRITE;
      ST_WRITE: w_state_next = w_frame_end ? ST_DONE : ST_FILL;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_pack  <= '0;
      r_be    <= '0;
      r_count <= '0;
      r_last  <= 1'b0;
      r_short <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_addr  <= bus.base_addr;
            r_pack  <= '0;
            r_be    <= '0;
            r_count <= '0;
            r_last  <= 1'b0;
            r_short <= 1'b0;
          end
        end
        ST_FILL: begin
          if (w_accept) begin
            r_pack[{w_lane, 3'b000} +: 8] <= bus.in_data;
            r_be[w_lane]                  <= 1'b1;
            r_count                       <= w_count_inc;
            r_last                        <= bus.in_last;
            // in_last on the final allowed byte is a normal end.
            if (bus.in_last && (w_count_inc < FRAME_LEN)) r_short <= 1'b1;
          end
        end
        ST_WRITE: begin
          r_addr <= r_addr + 17'd1;
          r_pack <= '0;
          r_be   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = (r_state == ST_FILL);
  assign bus.wren_a      = (r_state == ST_WRITE);
  assign bus.busy        = (r_state == ST_FILL) || (r_state == ST_WRITE);
  assign bus.done        = (r_state == ST_DONE);
  assign bus.address_a   = r_addr;
  assign bus.data_a      = r_pack;
  assign bus.byteena_a   = r_be;
  assign bus.short_frame = r_short;

endmodule

// File: tb/tb_pixel_ram_writer.sv
// Self-checking bench for pixel_ram_writer: directed frames with literal
// expectations plus randomized frames checked against a word-level model.
module tb_pixel_ram_writer;

  localparam int unsigned FB = 8;

  typedef struct packed {
    logic [16:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pixel_ram_writer_if bus();

  pixel_ram_writer #(.FRAME_BYTES(FB)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  wr_t exp_q[$];
  wr_t log_q[$];
  logic [7:0] frame_q[$];
  bit exp_short;
  int first_wr_cyc;
  int last_start_cyc;
  bit abort_mode;
  int abort_writes;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Every RAM write is compared against the model's next expected word.
  always @(negedge clk) begin : compare
    wr_t got;
    wr_t exp;
    if (rst_n && bus.wren_a) begin
      got.addr = bus.address_a;
      got.data = bus.data_a;
      got.be   = bus.byteena_a;
      if (abort_mode) abort_writes++;
      if (log_q.size() == 0) first_wr_cyc = cyc;
      log_q.push_back(got);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h be 0x%0h, required no write",
                 got.addr, got.data, got.be);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL write: got addr 0x%0h data 0x%0h be 0x%0h, required addr 0x%0h data 0x%0h be 0x%0h",
                   got.addr, got.data, got.be, exp.addr, exp.data, exp.be);
        end
      end
      check("ready_low_in_write", bus.in_ready, 0);
    end
  end

  // Frame -> list of word writes, from the packing rules alone.
  task automatic build_model(input logic [16:0] base);
    int n = frame_q.size();
    int acc = (n < int'(FB)) ? n : int'(FB);
    exp_short = (n < int'(FB));
    exp_q.delete();
    for (int w = 0; w * 4 < acc; w++) begin
      wr_t e;
      e.addr = base + 17'(w);
      e.data = '0;
      e.be   = '0;
      for (int k = 0; k < 4; k++) begin
        if (w * 4 + k < acc) begin
          e.data[8*k +: 8] = frame_q[w*4+k];
          e.be[k] = 1'b1;
        end
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_wren_a", bus.wren_a, 0);
    check("rst_address_a", bus.address_a, 0);
    check("rst_data_a", bus.data_a, 0);
    check("rst_byteena_a", bus.byteena_a, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_short_frame", bus.short_frame, 0);
  endtask

  task automatic run_frame(input logic [16:0] base, input bit rand_valid, input bit busy_starts);
    int n = frame_q.size();
    int acc = (n < int'(FB)) ? n : int'(FB);
    int idx = 0;
    bit got_done = 0;
    bit v;
    build_model(base);
    log_q.delete();
    @(negedge clk);
    bus.start = 1'b1;
    bus.base_addr = base;
    last_start_cyc = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    check("ready_after_start", bus.in_ready, 1);
    check("short_cleared_on_start", bus.short_frame, 0);
    for (int t = 0; t < 200; t++) begin
      if (bus.done) begin
        got_done = 1;
        break;
      end
      v = rand_valid ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (idx >= n) v = 1'b0;
      bus.in_valid = v;
      bus.in_data  = v ? frame_q[idx] : 8'($urandom);
      bus.in_last  = v && (idx == n - 1);
      if (busy_starts && ($urandom_range(0, 4) == 0)) begin
        bus.start = 1'b1;
        bus.base_addr = 17'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      if (v && bus.in_ready) idx++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.start    = 1'b0;
    check("done_seen", got_done, 1);
    check("busy_low_in_done", bus.busy, 0);
    check("short_frame", bus.short_frame, exp_short);
    check("bytes_accepted", idx, acc);
    check("writes_outstanding", exp_q.size(), 0);
    @(negedge clk);
    check("done_one_cycle", bus.done, 0);
    check("short_sticky", bus.short_frame, exp_short);
  endtask

  initial begin
    logic [16:0] base;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    abort_mode = 0;
    abort_writes = 0;
    #1;
    check_reset_outputs();
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // Full frame, in_valid held high.
    frame_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_frame(17'h00100, 0, 0);
    check("full_nwrites", log_q.size(), 2);
    check("full_w0", log_q[0], {17'h00100, 32'h04030201, 4'hF});
    check("full_w1", log_q[1], {17'h00101, 32'h08070605, 4'hF});
    check("first_write_latency", first_wr_cyc - last_start_cyc, 5);

    // Short frame; short_frame must stay up until the next start.
    frame_q = {8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    run_frame(17'h00100, 0, 0);
    check("short_nwrites", log_q.size(), 2);
    check("short_w1", log_q[1], {17'h00101, 32'h0000A5A4, 4'h3});
    repeat (3) @(negedge clk);
    check("short_still_set", bus.short_frame, 1);

    // Address wrap.
    frame_q = {8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    run_frame(17'h1FFFF, 0, 0);
    check("wrap_addr0", log_q[0].addr, 17'h1FFFF);
    check("wrap_addr1", log_q[1].addr, 17'h00000);

    // Stalls plus starts while busy: same words as the unstalled frame.
    frame_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_frame(17'h00100, 1, 1);
    check("stall_w0", log_q[0], {17'h00100, 32'h04030201, 4'hF});
    check("stall_w1", log_q[1], {17'h00101, 32'h08070605, 4'hF});

    // Reset after 3 accepted bytes.
    abort_mode = 1;
    abort_writes = 0;
    exp_q.delete();
    @(negedge clk);
    bus.start = 1'b1;
    bus.base_addr = 17'h00200;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 8'(8'h11 * (i + 1));
      bus.in_last = 1'b0;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    check("abort_no_write", abort_writes, 0);
    abort_mode = 0;
    rst_n = 1'b1;
    frame_q = {8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
    run_frame(17'h0ABCD, 0, 0);
    check("post_reset_w0", log_q[0], {17'h0ABCD, 32'hC3C2C1C0, 4'hF});
    check("post_reset_w1", log_q[1], {17'h0ABCE, 32'h000000C4, 4'h1});

    // Randomized frames: lengths below, at and above FRAME_BYTES.
    for (int f = 0; f < 30; f++) begin
      int n = $urandom_range(1, 12);
      frame_q.delete();
      for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom));
      if ($urandom_range(0, 3) == 0) base = 17'h1FFFF - 17'($urandom_range(0, 2));
      else base = 17'($urandom);
      run_frame(base, 1, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_ram_writer.md
PIXEL_RAM_WRITER -- requirements
Module: pixel_ram_writer

Interface
REQ-001 Parameter FRAME_BYTES, default 65536; bytes per frame (256x256 8-bit pixels), SHALL be a multiple of 4 and <= 524288.
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to begin a frame load.
REQ-005 base_addr  input  17  first word address; sampled on an accepted start.
REQ-006 in_valid  input  1  in_data/in_last valid.
REQ-007 in_ready  output  1  writer accepts a byte this cycle.
REQ-008 in_data  input  8  pixel byte.
REQ-009 in_last  input  1  marks the final byte of the frame.
REQ-010 address_a  output  17  RAM port-A word address.
REQ-011 data_a  output  32  RAM port-A write data.
REQ-012 byteena_a  output  4  RAM port-A byte enables.
REQ-013 wren_a  output  1  RAM port-A write strobe.
REQ-014 busy  output  1  high from an accepted start until done.
REQ-015 done  output  1  one-cycle pulse when the frame load completes.
REQ-016 short_frame  output  1  sticky: in_last arrived before FRAME_BYTES bytes.

Function
REQ-017 The FSM SHALL have the states IDLE, FILL, WRITE and DONE.
REQ-018 IDLE: start=1 -> latch base_addr, clear byte count and short_frame, go to FILL; start is ignored in all other states.
REQ-019 A byte is accepted when in_valid and in_ready are both 1; in_ready SHALL be 1 only in FILL.
REQ-020 Packing is little-endian: the k-th accepted byte of a word (k=0..3) SHALL go to data_a[8k+7:8k] and set byteena_a[k].
REQ-021 FILL -> WRITE after the 4th byte of a word, after a byte with in_last=1, or after the byte that makes count == FRAME_BYTES.
REQ-022 WRITE (exactly 1 cycle): wren_a=1 with the packed data_a/byteena_a and the current address_a; otherwise wren_a=0.
REQ-023 A partial word (in_last on byte k<3) SHALL be written with only byteena_a[k:0] set; unfilled data_a bytes are 0.
REQ-024 After WRITE, address_a SHALL increment by 1 modulo 2^17 (0x1FFFF wraps to 0x00000), and the pack register and byteena SHALL clear.
REQ-025 WRITE -> DONE if the written word held in_last or count == FRAME_BYTES; otherwise WRITE -> FILL.
REQ-026 DONE (1 cycle): done=1, busy=0; next state IDLE.
REQ-027 If in_last arrives with count < FRAME_BYTES, short_frame SHALL be set; it holds until the next accepted start.
REQ-028 If count reaches FRAME_BYTES without in_last, the frame SHALL still end; later bytes are not accepted until the next start.
REQ-029 in_last on the FRAME_BYTES-th byte is a normal end and SHALL NOT set short_frame.
REQ-030 The byte counter SHALL be 20 bits wide and SHALL NOT wrap within a frame.
REQ-031 Throughput: 4 bytes per 5 cycles with in_valid held high; the first word write occurs 5 cycles after the start cycle.
REQ-032 The block never reads the RAM; the read port and the VGA path are untouched.

Reset
REQ-033 With reset=0, asynchronously: state=IDLE, in_ready=0, wren_a=0, address_a=0, data_a=0, byteena_a=0, busy=0, done=0, short_frame=0, count=0.
REQ-034 Reset asserted mid-frame SHALL abort the frame immediately with no further write; no done pulse is issued.
REQ-035 After reset deassertion, the block SHALL wait in IDLE for start.

Verification
REQ-036 Full frame: base_addr=0x00100, FRAME_BYTES=8, bytes 0x01..0x08 with in_last on the 8th -> two writes: 0x00100 data 0x04030201 be 0xF, then 0x00101 data 0x08070605 be 0xF; done pulses; short_frame=0.
REQ-037 Short frame: 6 bytes 0xA0..0xA5 with in_last on 0xA5 -> second write at base+1 with data 0x0000A5A4, be 0x3; short_frame=1 until next start.
REQ-038 Address wrap: base_addr=0x1FFFF, 8 bytes -> writes at 0x1FFFF then 0x00000.
REQ-039 Backpressure and stalls: in_valid toggled randomly -> data identical to the no-stall case; in_ready=0 in WRITE; no byte lost or duplicated.
REQ-040 Reset mid-frame after 3 bytes -> wren_a never asserts and all outputs go to reset values; a new start then loads correctly from the new base_addr.
REQ-041 Start while busy -> ignored: base_addr and address sequence unchanged.
